// File: rtl/term_text_engine.sv
// term_text_engine: character-cell terminal core.
// Consumes a byte stream, interprets CR/LF/BS/FF, writes glyph codes into a
// ring-buffered COLS x ROWS framebuffer and serves a registered read port
// with a blinking cursor overlaid on the read data.
module term_text_engine #(
    parameter int          COLS        = 80,
    parameter int          ROWS        = 30,
    parameter int          BLINK_BITS  = 23,
    parameter bit          CURSOR_EN   = 1'b1,
    parameter logic [7:0]  CURSOR_CHAR = 8'd95,
    parameter logic [7:0]  BLANK_CHAR  = 8'd32,
    localparam int         CW          = $clog2(COLS),
    localparam int         RW          = $clog2(ROWS)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_valid,
    input  logic [7:0]    in_data,
    output logic          in_ready,
    input  logic [CW-1:0] rd_col,
    input  logic [RW-1:0] rd_row,
    output logic [7:0]    rd_char,
    output logic [CW-1:0] cur_col,
    output logic [RW-1:0] cur_row,
    output logic          busy
);

    localparam int DEPTH = COLS * ROWS;
    localparam int AW    = $clog2(DEPTH);
    localparam int RW1   = RW + 1;

    localparam logic [CW-1:0]  COL_LAST  = CW'(COLS - 1);
    localparam logic [RW-1:0]  ROW_LAST  = RW'(ROWS - 1);
    localparam logic [AW-1:0]  CELL_LAST = AW'(DEPTH - 1);
    localparam logic [AW-1:0]  SCROLL_LAST = AW'(COLS - 1);
    localparam logic [RW1-1:0] ROWS_EXT  = RW1'(ROWS);

    typedef enum logic [1:0] {
        ST_CLEAR  = 2'd0,
        ST_IDLE   = 2'd1,
        ST_SCROLL = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [AW-1:0]        idx_q, idx_d;
    logic [RW-1:0]        top_q, top_d;
    logic [CW-1:0]        cur_col_q, cur_col_d;
    logic [RW-1:0]        cur_row_q, cur_row_d;
    logic [BLINK_BITS-1:0] blink_cnt_q, blink_cnt_d;
    logic                 blink_on_q, blink_on_d;
    logic [CW-1:0]        rd_col_q, rd_col_d;
    logic [RW-1:0]        rd_row_q, rd_row_d;
    logic                 rd_hold_q, rd_hold_d;

    logic [7:0]           mem [DEPTH];
    logic [7:0]           mem_rd_q;

    logic                 wr_en;
    logic [AW-1:0]        wr_addr;
    logic [7:0]           wr_data;
    logic [AW-1:0]        rd_addr;
    logic                 accept;
    logic                 newline_req;
    logic                 cursor_hit;

    // Logical row -> physical cell address through the ring offset; the
    // sum of two in-range rows is below 2*ROWS, so one subtract replaces a divider.
    function automatic logic [AW-1:0] cell_addr(input logic [RW-1:0] row,
                                                 input logic [CW-1:0] col,
                                                 input logic [RW-1:0] top);
        logic [RW1-1:0] sum;
        sum = {1'b0, row} + {1'b0, top};
        if (sum >= ROWS_EXT) begin
            sum = sum - ROWS_EXT;
        end
        return AW'(sum[RW-1:0]) * AW'(COLS) + AW'(col);
    endfunction

    // State and datapath registers, with reset restarting a full clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_CLEAR;
            idx_q       <= '0;
            top_q       <= '0;
            cur_col_q   <= '0;
            cur_row_q   <= '0;
            blink_cnt_q <= '0;
            blink_on_q  <= 1'b1;
            rd_col_q    <= '0;
            rd_row_q    <= '0;
            rd_hold_q   <= 1'b1;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            top_q       <= top_d;
            cur_col_q   <= cur_col_d;
            cur_row_q   <= cur_row_d;
            blink_cnt_q <= blink_cnt_d;
            blink_on_q  <= blink_on_d;
            rd_col_q    <= rd_col_d;
            rd_row_q    <= rd_row_d;
            rd_hold_q   <= rd_hold_d;
        end
    end

    // Framebuffer: one write port, one registered read port that returns
    // the old contents when both hit the same cell in the same cycle.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        mem_rd_q <= mem[rd_addr];
    end

    // Next-state logic: byte interpretation, clear sweep and scroll line clear.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        top_d       = top_q;
        cur_col_d   = cur_col_q;
        cur_row_d   = cur_row_q;
        blink_cnt_d = blink_cnt_q + 1'b1;
        blink_on_d  = (&blink_cnt_q) ? ~blink_on_q : blink_on_q;
        rd_col_d    = rd_col;
        rd_row_d    = rd_row;
        rd_hold_d   = 1'b0;
        rd_addr     = cell_addr(rd_row, rd_col, top_q);
        wr_en       = 1'b0;
        wr_addr     = cell_addr(cur_row_q, cur_col_q, top_q);
        wr_data     = in_data;
        newline_req = 1'b0;
        accept      = in_valid && (state_q == ST_IDLE);

        case (state_q)
            ST_CLEAR: begin
                wr_en     = 1'b1;
                wr_addr   = idx_q;
                wr_data   = BLANK_CHAR;
                top_d     = '0;
                cur_col_d = '0;
                cur_row_d = '0;
                if (idx_q == CELL_LAST) begin
                    idx_d   = '0;
                    state_d = ST_IDLE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            ST_IDLE: begin
                if (accept) begin
                    if (in_data >= 8'h20 && in_data <= 8'h7E) begin
                        wr_en = 1'b1;
                        if (cur_col_q < COL_LAST) begin
                            cur_col_d = cur_col_q + 1'b1;
                        end else begin
                            cur_col_d   = '0;
                            newline_req = 1'b1;
                        end
                    end else if (in_data == 8'h0D) begin
                        cur_col_d = '0;
                    end else if (in_data == 8'h0A) begin
                        newline_req = 1'b1;
                    end else if (in_data == 8'h08) begin
                        if (cur_col_q != '0) begin
                            cur_col_d = cur_col_q - 1'b1;
                        end
                    end else if (in_data == 8'h0C) begin
                        state_d   = ST_CLEAR;
                        idx_d     = '0;
                        top_d     = '0;
                        cur_col_d = '0;
                        cur_row_d = '0;
                    end
                end
                if (newline_req) begin
                    if (cur_row_q < ROW_LAST) begin
                        cur_row_d = cur_row_q + 1'b1;
                    end else begin
                        state_d = ST_SCROLL;
                        idx_d   = '0;
                        top_d   = (top_q == ROW_LAST) ? '0 : top_q + 1'b1;
                    end
                end
            end
            ST_SCROLL: begin
                // top already advanced, so the bottom logical row is the old top row
                wr_en   = 1'b1;
                wr_addr = cell_addr(ROW_LAST, idx_q[CW-1:0], top_q);
                wr_data = BLANK_CHAR;
                if (idx_q == SCROLL_LAST) begin
                    idx_d   = '0;
                    state_d = ST_IDLE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_CLEAR;
                idx_d   = '0;
            end
        endcase
    end

    // Outputs: handshake from state only, cursor overlay on registered read data.
    always_comb begin
        in_ready   = (state_q == ST_IDLE);
        busy       = (state_q != ST_IDLE);
        cur_col    = cur_col_q;
        cur_row    = cur_row_q;
        cursor_hit = CURSOR_EN && blink_on_q && (state_q == ST_IDLE) &&
                     (rd_col_q == cur_col_q) && (rd_row_q == cur_row_q);
        if (rd_hold_q) begin
            rd_char = BLANK_CHAR;
        end else if (cursor_hit) begin
            rd_char = CURSOR_CHAR;
        end else begin
            rd_char = mem_rd_q;
        end
    end

endmodule
